// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-cache link (PC out, instruction in), the pipeline
// control inputs (en, stall, redirect) and the IF/ID register outputs.
//   master : the fetch unit (drives PC and the IF/ID outputs)
//   slave  : the environment (cache + pipeline control)
interface inst_fetch_unit_if;
  logic        en;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] instruction;
  logic [7:0]  PC;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        halted;

  modport master (
    input  en, stall, redirect_valid, redirect_pc, instruction,
    output PC, if_instr, if_pc, if_valid, halted
  );

  modport slave (
    output en, stall, redirect_valid, redirect_pc, instruction,
    input  PC, if_instr, if_pc, if_valid, halted
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit.
// Owns the 8-bit program counter, presents it to the instruction cache and
// latches the returned word into the IF/ID register. Supports stall/enable
// hold, execute-stage redirects (one bubble) and a permanent halt when a
// jump-to-self (opcode 4'b1000, target == PC) is fetched.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - inst_fetch_unit_if.master: en, stall, redirect_valid,
//           redirect_pc, instruction in; PC, if_instr, if_pc, if_valid,
//           halted out (all outputs registered)
module inst_fetch_unit #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [15:0] NOP_WORD    = 16'h0000,
  parameter bit          HALT_DETECT = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [3:0] OP_JUMP = 4'b1000;

  logic [1:0]  state_q,    state_d;
  logic [7:0]  pc_q,       pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [7:0]  if_pc_q,    if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q,   halted_d;

  logic advance;
  logic self_jump;

  assign advance   = bus.en && !bus.stall;
  // A jump whose target is its own address can never make progress.
  assign self_jump = HALT_DETECT
                     && (bus.instruction[15:12] == OP_JUMP)
                     && (bus.instruction[7:0] == pc_q);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;

    case (state_q)
      ST_IDLE: begin
        // Start-up edge: only the state moves; no word is latched yet.
        if (bus.en) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.redirect_valid) begin
          // Redirect wins over stall, enable and halt detection; the word
          // fetched from the old PC is squashed into a bubble.
          pc_d       = bus.redirect_pc;
          if_instr_d = NOP_WORD;
          if_valid_d = 1'b0;
        end else if (advance) begin
          if_instr_d = bus.instruction;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (self_jump) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end
      end

      ST_HALT: begin
        // Frozen until reset; only the valid flag drops.
        if_valid_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_WORD;
      if_pc_q    <= 8'h00;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. Two instances run side by side
// on identical control inputs: one with halt detection, one without. Each
// fetches from its own PC into a shared 256-word instruction memory.
module tb_inst_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, stall, rv;
  logic [7:0]  rpc;
  logic [15:0] mem [256];
  bit          cmp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_unit_if bus_h ();
  inst_fetch_unit_if bus_n ();

  assign bus_h.en             = en;
  assign bus_h.stall          = stall;
  assign bus_h.redirect_valid = rv;
  assign bus_h.redirect_pc    = rpc;
  assign bus_h.instruction    = mem[bus_h.PC];
  assign bus_n.en             = en;
  assign bus_n.stall          = stall;
  assign bus_n.redirect_valid = rv;
  assign bus_n.redirect_pc    = rpc;
  assign bus_n.instruction    = mem[bus_n.PC];

  inst_fetch_unit #(.HALT_DETECT(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h.master));
  inst_fetch_unit #(.HALT_DETECT(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.master));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          running;  // has left the post-reset idle edge
    bit          halt;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [7:0]  ipc;
    bit          iv;
  } mstate_t;

  mstate_t mdl [2];

  function automatic mstate_t reset_state();
    mstate_t s;
    s.running = 1'b0; s.halt = 1'b0; s.pc = 8'h00;
    s.instr = NOP; s.ipc = 8'h00; s.iv = 1'b0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit hd, input bit e,
                                   input bit st, input bit r, input logic [7:0] rt,
                                   input logic [15:0] word);
    mstate_t n = s;
    if (s.halt) begin
      n.iv = 1'b0;
    end else if (!s.running) begin
      if (e) n.running = 1'b1;
    end else if (r) begin
      n.pc = rt; n.instr = NOP; n.iv = 1'b0;
    end else if (e && !st) begin
      n.instr = word; n.ipc = s.pc; n.iv = 1'b1;
      if (hd && word[15:12] == 4'h8 && word[7:0] == s.pc) n.halt = 1'b1;
      else n.pc = 8'((int'(s.pc) + 1) % 256);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] = reset_state();
      mdl[1] = reset_state();
    end else begin
      mdl[0] = step(mdl[0], 1'b1, en, stall, rv, rpc, mem[mdl[0].pc]);
      mdl[1] = step(mdl[1], 1'b0, en, stall, rv, rpc, mem[mdl[1].pc]);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("h.PC",       bus_h.PC,       mdl[0].pc);
      check("h.if_instr", bus_h.if_instr, mdl[0].instr);
      check("h.if_pc",    bus_h.if_pc,    mdl[0].ipc);
      check("h.if_valid", bus_h.if_valid, mdl[0].iv);
      check("h.halted",   bus_h.halted,   mdl[0].halt);
      check("n.PC",       bus_n.PC,       mdl[1].pc);
      check("n.if_instr", bus_n.if_instr, mdl[1].instr);
      check("n.if_pc",    bus_n.if_pc,    mdl[1].ipc);
      check("n.if_valid", bus_n.if_valid, mdl[1].iv);
      check("n.halted",   bus_n.halted,   mdl[1].halt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [7:0] t);
    rv = 1'b1; rpc = t;
    tick();
    rv = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " PC"},       bus_h.PC,       8'h00);
    check({tag, " if_valid"}, bus_h.if_valid, 1'b0);
    check({tag, " if_instr"}, bus_h.if_instr, 16'h0000);
    check({tag, " if_pc"},    bus_h.if_pc,    8'h00);
    check({tag, " halted"},   bus_h.halted,   1'b0);
    check({tag, " n.PC"},     bus_n.PC,       8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    en = 1'b0; stall = 1'b0; rv = 1'b0; rpc = 8'h00; rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[8'hD2] = 16'h80D2;

    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    @(negedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Sequential fetch; first edge only leaves idle.
    en = 1'b1;
    tick();
    check("idle edge PC",       bus_h.PC,       8'h00);
    check("idle edge if_valid", bus_h.if_valid, 1'b0);
    tick();
    check("fetch0 if_pc",    bus_h.if_pc,    8'h00);
    check("fetch0 if_instr", bus_h.if_instr, 16'h1000);
    check("fetch0 PC",       bus_h.PC,       8'h01);
    repeat (4) tick();
    check("seq PC",    bus_h.PC,    8'h05);
    check("seq if_pc", bus_h.if_pc, 8'h04);

    // Stall three cycles at PC=05.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall PC",    bus_h.PC,    8'h05);
      check("stall if_pc", bus_h.if_pc, 8'h04);
    end
    stall = 1'b0;
    tick();
    check("unstall if_pc", bus_h.if_pc, 8'h05);
    check("unstall PC",    bus_h.PC,    8'h06);

    // Redirect 22 -> 7B, plain and with stall in the same cycle.
    for (int k = 0; k < 2; k++) begin
      redirect(8'h22);
      check("redir setup PC", bus_h.PC, 8'h22);
      rv = 1'b1; rpc = 8'h7B; stall = (k == 1);
      tick();
      rv = 1'b0; stall = 1'b0;
      check("redir PC",       bus_h.PC,       8'h7B);
      check("redir if_valid", bus_h.if_valid, 1'b0);
      check("redir if_instr", bus_h.if_instr, 16'h0000);
      tick();
      check("post-redir if_pc",    bus_h.if_pc,    8'h7B);
      check("post-redir if_valid", bus_h.if_valid, 1'b1);
      check("post-redir if_instr", bus_h.if_instr, 16'h107B);
    end

    // PC wrap FE, FF, 00.
    redirect(8'hFE);
    check("wrap PC FE", bus_h.PC, 8'hFE);
    tick(); check("wrap if_pc FE", bus_h.if_pc, 8'hFE); check("wrap PC FF", bus_h.PC, 8'hFF);
    tick(); check("wrap if_pc FF", bus_h.if_pc, 8'hFF); check("wrap PC 00", bus_h.PC, 8'h00);
    tick(); check("wrap if_pc 00", bus_h.if_pc, 8'h00);

    // Redirect beats halt detection on a self-jump word.
    redirect(8'hD2);
    rv = 1'b1; rpc = 8'h10;
    tick();
    rv = 1'b0;
    check("redir>halt PC",     bus_h.PC,     8'h10);
    check("redir>halt halted", bus_h.halted, 1'b0);
    check("redir>halt n.PC",   bus_n.PC,     8'h10);

    // Halt on self-jump.
    redirect(8'hD2);
    tick();
    check("halt if_instr", bus_h.if_instr, 16'h80D2);
    check("halt if_valid", bus_h.if_valid, 1'b1);
    check("halt halted",   bus_h.halted,   1'b1);
    check("halt PC",       bus_h.PC,       8'hD2);
    check("nohalt PC",     bus_n.PC,       8'hD3);
    check("nohalt halted", bus_n.halted,   1'b0);
    tick();
    check("halt+1 if_valid", bus_h.if_valid, 1'b0);
    rv = 1'b1; rpc = 8'h33;
    tick(); tick();
    rv = 1'b0;
    check("halt ignores redir PC",     bus_h.PC,       8'hD2);
    check("halt ignores redir halted", bus_h.halted,   1'b1);
    check("halt frozen if_instr",      bus_h.if_instr, 16'h80D2);

    // Mid-run asynchronous reset.
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Randomized phase with occasional self-jumps and resets.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 63) == 0) mem[i] = {4'h8, 4'($urandom), 8'(i)};
    end
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      rv    = ($urandom_range(0, 9) == 0);
      rpc   = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
